// File: rtl/logic_vector_checker.sv
`default_nettype none
// ============================================================================
//  Module   : logic_vector_checker
//  Purpose  : Exhaustive stimulus-and-check engine for a 4-input gate network.
//             Drives vec = 0..15, holds each vector for DWELL cycles, samples
//             the network response on the last dwell cycle and compares it
//             with the EXPECT truth table. Reports the mismatch count, the
//             first failing vector and an overall pass flag.
//  Revision : 1.0 - initial release
// ============================================================================
module logic_vector_checker #(
  parameter int unsigned DWELL  = 4,        // cycles per vector, 1..255
  parameter logic [15:0] EXPECT = 16'hBFBF  // bit i = expected y for vec=i
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       dut_y_i,
  output logic [3:0] vec_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       pass_o,
  output logic [4:0] err_cnt_o,
  output logic [3:0] first_fail_o,
  output logic       first_fail_vld_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Terminal value of the dwell counter: the sampling cycle of each vector.
  localparam logic [7:0] C_DWELL_LAST = 8'(DWELL - 1);
  localparam logic [3:0] C_VEC_LAST   = 4'd15;

  state_t      state_q;
  logic [7:0]  dwell_q;
  logic [3:0]  vec_q;
  logic        busy_q;
  logic        done_q;
  logic        pass_q;
  logic [4:0]  err_cnt_q;
  logic [3:0]  first_fail_q;
  logic        first_fail_vld_q;

  logic        w_sample;
  logic        w_mismatch;
  logic        w_start_ok;
  logic [7:0]  dwell_d;
  logic [3:0]  vec_d;
  logic [4:0]  err_cnt_d;

  // Sample/compare decode and next values of the counters.
  always_comb begin
    w_sample   = (state_q == S_DRIVE) && (dwell_q == C_DWELL_LAST);
    w_mismatch = w_sample && (dut_y_i != EXPECT[vec_q]);
    w_start_ok = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));
    dwell_d    = dwell_q + 8'd1;
    vec_d      = vec_q + 4'd1;            // natural wrap 15 -> 0 ends the run
    err_cnt_d  = err_cnt_q + {4'd0, w_mismatch};
  end

  // Run-control FSM with all status outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= S_IDLE;
      dwell_q          <= 8'd0;
      vec_q            <= 4'd0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      err_cnt_q        <= 5'd0;
      first_fail_q     <= 4'd0;
      first_fail_vld_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          // A new run clears every piece of status from the previous one.
          if (w_start_ok) begin
            state_q          <= S_DRIVE;
            dwell_q          <= 8'd0;
            vec_q            <= 4'd0;
            busy_q           <= 1'b1;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            err_cnt_q        <= 5'd0;
            first_fail_q     <= 4'd0;
            first_fail_vld_q <= 1'b0;
          end
        end

        S_DRIVE: begin
          // start is deliberately not looked at here.
          if (w_sample) begin
            dwell_q   <= 8'd0;
            vec_q     <= vec_d;
            err_cnt_q <= err_cnt_d;
            if (w_mismatch && !first_fail_vld_q) begin
              first_fail_q     <= vec_q;
              first_fail_vld_q <= 1'b1;
            end
            // Last vector sampled: busy falls on the same edge done rises.
            if (vec_q == C_VEC_LAST) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_cnt_d == 5'd0);
            end
          end else begin
            dwell_q <= dwell_d;
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          pass_q  <= 1'b0;
        end
      endcase
    end
  end

  assign vec_o            = vec_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign pass_o           = pass_q;
  assign err_cnt_o        = err_cnt_q;
  assign first_fail_o     = first_fail_q;
  assign first_fail_vld_o = first_fail_vld_q;

endmodule
`default_nettype wire

// File: doc/logic_vector_checker.md
# logic_vector_checker

Synthesizable stimulus-and-check engine for the 4-input basic gate network (`a,b,c,d -> y`). It is the hardware counterpart of the bench stimulus. It drives all 16 input combinations in order, holds each for a fixed dwell time, and samples the network's `y` response. It compares `y` against a parameterized truth table and reports mismatch count, first failing vector and pass/fail. It sits beside the gate network on the FPGA, with `vec` wired to the network inputs and the network output wired to `dut_y`.

## Interface
- `DWELL`, default 4: cycles each vector is held before `y` is sampled. Legal range 1..255.
- `EXPECT`, default 16'hBFBF: expected `y` per vector, where bit i is the expected `y` for vec=i. The default encodes `y = ~(b&c) | d`, which is 0 only at vec 6 and 14.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: one clock; reset is asynchronous and active-high.
- `start` in 1: one-cycle pulse that begins a run. Accepted only in IDLE or DONE.
- `dut_y` in 1: response of the gate network. Synchronous to `clk`, combinational from `vec`.
- `vec` out 4: drives network inputs. `vec[3]=a`, `vec[2]=b`, `vec[1]=c`, `vec[0]=d`.
- `busy` out 1: high while a run is in progress.
- `done` out 1: high from run completion until the next accepted `start` or `rst`.
- `pass` out 1: `done && err_cnt==0`, registered.
- `err_cnt` out 5: number of mismatching vectors in the current/last run, 0..16.
- `first_fail` out 4: index of the first mismatching vector. Valid only when `first_fail_vld=1`.
- `first_fail_vld` out 1: set on the first mismatch of a run.

## Operation
- FSM states: IDLE, DRIVE, DONE.
- IDLE: `vec=0`, all status outputs 0. `start` moves to DRIVE and clears the dwell counter, `err_cnt`, `first_fail` and `first_fail_vld`.
- DRIVE:
  - `busy=1` and `vec` is held constant while the dwell counter counts 0..DWELL-1.
  - On the edge where the counter equals DWELL-1, `dut_y` is sampled and compared with `EXPECT[vec]`.
  - On mismatch, `err_cnt` increments. If `first_fail_vld=0`, then `first_fail<=vec` and `first_fail_vld<=1`.
  - On the same edge, the counter returns to 0 and `vec` increments.
  - When vec=15 is sampled, the FSM moves to DONE instead, and `vec` wraps to 0.
- DONE: `busy=0`, `done=1`, `pass` valid. `err_cnt`, `first_fail` and `first_fail_vld` hold. `start` restarts the run: all status is cleared and the FSM goes to DRIVE.
- `start` while in DRIVE is ignored and has no effect on the run.
- `err_cnt` is 5 bits so 16 mismatches are representable. No saturation logic is needed.
- The comparison is `dut_y != EXPECT[vec]`, using the `vec` value held during that dwell window.

## Timing
- Reset values: `vec=0`, `busy=0`, `done=0`, `pass=0`, `err_cnt=0`, `first_fail=0`, `first_fail_vld=0`, FSM in IDLE, dwell counter 0.
- `start` is sampled at edge E0. `busy` rises and `vec=0` is presented after E0.
- Vector k is presented after edge E0+k·DWELL. It is sampled at edge E0+(k+1)·DWELL.
- `done` and `pass` are valid after edge E0+16·DWELL. At that same edge `busy` falls, so `busy` and `done` never overlap.
- Total run length is 16·DWELL cycles. With DWELL=4 that is 64 cycles.
- `err_cnt` and `first_fail*` update on the sampling edge. They are visible the following cycle.
- `rst` asserted at any time, including mid-DRIVE, immediately forces all reset values regardless of `clk`. A run aborted by reset is not resumed.
- After `rst` deasserts, the FSM is in IDLE and waits for `start`.
- `start` and `rst` together: reset wins.

## Test plan
- Correct network model (`y=~(b&c)|d`), DWELL=4, `start` pulse:
  - `vec` steps 0..15, each held for 4 cycles.
  - After 64 cycles: `done=1`, `pass=1`, `err_cnt=0`, `first_fail_vld=0`.
- `dut_y` stuck at 1:
  - `err_cnt=2`, `first_fail=6`, `first_fail_vld=1`, `pass=0`.
- `dut_y` stuck at 0:
  - `err_cnt=14`, `first_fail=0`, `pass=0`.
- Second `start` pulse at cycle 20 of a run with the correct model:
  - Ignored; `done` still rises at cycle 64 with `err_cnt=0`.
- `rst` pulse at cycle 30 of a run:
  - All outputs return to reset values asynchronously.
  - A new `start` then completes normally in 64 cycles.
- DWELL=1, stuck-at-1 model, run twice back-to-back via `start` in DONE:
  - Each run takes 16 cycles.
  - `err_cnt` is cleared at the second `start` and reads 2 again at the end.
